pwm_deadtime_wb: RTL and testbench
==================================

// Module: pwm_deadtime_wb
// PURPOSE
//  Complementary-output stage fed by pwm_wb.pwm_out on the same clock. Converts single PWM into
//  high-side/low-side gate drives with programmable dead time, per-output polarity, and a
//  latched external fault shutdown. Wishbone CSR slave; one instance per half-bridge.
// PARAMETERS
//  DT_BITS     8   width of dead-time register and counter (1..16)
// PORTS
//  wb_clk_i     in   1   clock; shared with pwm_wb
//  wb_resetb_i  in   1   asynchronous active-low reset
//  wb_stb_i     in   1   Wishbone strobe
//  wb_cyc_i     in   1   Wishbone cycle
//  wb_we_i      in   1   write enable
//  wb_sel_i     in   4   byte selects; any bit set = full-width write
//  wb_dat_i     in   32  write data
//  wb_adr_i     in   32  address; only [7:0] decoded
//  wb_ack_o     out  1   single-cycle ack
//  wb_dat_o     out  32  read data, valid with ack
//  pwm_in       in   1   PWM from pwm_wb (registered, same clock domain)
//  fault_i      in   1   async active-high fault; synchronised internally
//  pwm_hi_o     out  1   high-side drive, active level = !CTRL.HI_INV
//  pwm_lo_o     out  1   low-side drive, active level = !CTRL.LO_INV
//  fault_irq_o  out  1   level IRQ = FAULT_LATCHED & CTRL.IRQ_EN
// BEHAVIOUR
//  CSRs: 0x00 CTRL [0]EN [1]HI_INV [2]LO_INV [3]IRQ_EN [4]FAULT_CLR (write-only, self-clearing, reads 0)
//        0x04 DEADTIME [DT_BITS-1:0];  0x08 STATUS (RO) [0]FAULT_LATCHED [1]FAULT_SYNC [4:2]STATE
//  Reset: all CSRs 0, state OFF, pwm_hi_o=pwm_lo_o=0, wb_ack_o=0, wb_dat_o=0, sync flops 0.
//  Bus: stb&cyc&!ack -> ack=1 next edge, then 0 (one cycle min between acks). Write iff we & |sel.
//   Reads return the addressed reg zero-extended; unmapped read -> 0; writes to 0x08/unmapped ignored.
//  Fault: fault_i -> 2-flop sync -> FAULT_SYNC. FAULT_SYNC=1 sets FAULT_LATCHED; cleared only by
//   FAULT_CLR write while FAULT_SYNC=0 (clr with fault still present: no effect; set wins).
//  FSM (state/outputs are flops updated on the same edge; outputs decode next state):
//   OFF(0): both inactive. EN & !FAULT_LATCHED -> DEAD, target=pwm_in, dt_cnt=0.
//   DEAD(1): both inactive; dt_cnt+=1 per cycle. pwm_in!=target -> target=pwm_in, dt_cnt=0 (restart).
//     Else dt_cnt==DEADTIME -> HI if target else LO. Dead interval = DEADTIME+1 cycles; 0 -> 1 cycle.
//   HI(2): hi active. pwm_in==0 -> DEAD target=0, dt_cnt=0.
//   LO(3): lo active. pwm_in==1 -> DEAD target=1, dt_cnt=0.
//   FAULT(4): both inactive. Leave to OFF when FAULT_LATCHED==0.
//   Priority every state: FAULT_SYNC|FAULT_LATCHED -> FAULT; else !EN -> OFF; else rules above.
//  Invariant: hi and lo are never simultaneously active; every hi<->lo swap passes through DEAD.
//  Latency: pwm_in change sampled at edge k -> active side off after edge k; other side on after
//   edge k+DEADTIME+1. fault_i rise -> both outputs inactive after 3rd edge.
//  Polarity: output = active ^ INV; polarity write takes effect next edge in any state (incl OFF/FAULT).
//  DEADTIME write mid-DEAD: new value compared immediately; if dt_cnt already > new value, the
//   counter wraps at 2^DT_BITS (no early exit) -- software must update only while EN=0.
//  pwm_in pulse shorter than DEADTIME+1: restarts DEAD each edge, outputs stay inactive.
//  Async reset mid-operation: outputs inactive immediately, FAULT_LATCHED cleared.
// TESTING
//  1 DEADTIME=3, EN=1, pwm_in 0 for 10 cyc then 1 -> lo active, then lo off edge k, hi on edge k+4.
//  2 pwm_wb-style 50% square, period 20, DEADTIME=2 -> hi/lo never overlap; each gap exactly 3 cyc.
//  3 In HI, fault_i=1 -> both inactive after 3 edges, STATUS=0x13; FAULT_CLR with fault high -> stays;
//    drop fault, FAULT_CLR -> OFF then DEAD, IRQ_EN=1 shows fault_irq_o high until clear.
//  4 HI_INV=LO_INV=1, EN=0 -> pwm_hi_o=pwm_lo_o=1; EN=1 in LO -> pwm_lo_o=0, pwm_hi_o=1.
//  5 pwm_in 1-cycle glitches every 2 cyc, DEADTIME=4 -> outputs remain inactive, state stays DEAD.
//  6 Bus: write DEADTIME=0xA5 then read -> 0xA5, ack exactly 1 cycle; read 0x40 -> 0; reset mid-HI -> all 0.

Source files
------------

// File: rtl/pwm_deadtime_wb.sv
// ============================================================================
// Module  : pwm_deadtime_wb
// Brief   : Complementary high/low gate-drive stage with programmable dead
//           time, per-output polarity, latched fault shutdown, Wishbone CSRs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_deadtime_wb #(
    parameter int DT_BITS = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_resetb_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic        pwm_in,
    input  logic        fault_i,
    output logic        pwm_hi_o,
    output logic        pwm_lo_o,
    output logic        fault_irq_o
);

    localparam logic [7:0] C_ADR_CTRL   = 8'h00;
    localparam logic [7:0] C_ADR_DT     = 8'h04;
    localparam logic [7:0] C_ADR_STATUS = 8'h08;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_DEAD  = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // CSR storage
    logic               r_en;
    logic               r_hi_inv;
    logic               r_lo_inv;
    logic               r_irq_en;
    logic [DT_BITS-1:0] r_deadtime;

    // Bus
    logic               r_ack;
    logic [31:0]        r_dat;
    logic               w_req;
    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_dt;
    logic               w_fault_clr;
    logic [7:0]         w_adr;
    logic [31:0]        w_rdata;

    // Fault path
    logic               r_fault_meta;
    logic               r_fault_sync;
    logic               r_fault_latched;

    // FSM
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_target;
    logic               w_target_nxt;
    logic [DT_BITS-1:0] r_dt_cnt;
    logic [DT_BITS-1:0] w_dt_cnt_nxt;
    logic               r_hi;
    logic               r_lo;
    logic               w_hi_inv_nxt;
    logic               w_lo_inv_nxt;

    logic               w_unused_bits;
    assign w_unused_bits = ^{wb_adr_i[31:8], wb_dat_i};

    // ------------------------------------------------------------------
    // Wishbone decode: one request per ack, ack always drops for a cycle
    // ------------------------------------------------------------------
    assign w_adr       = wb_adr_i[7:0];
    assign w_req       = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr        = w_req & wb_we_i & (|wb_sel_i);
    assign w_wr_ctrl   = w_wr && (w_adr == C_ADR_CTRL);
    assign w_wr_dt     = w_wr && (w_adr == C_ADR_DT);
    assign w_fault_clr = w_wr_ctrl & wb_dat_i[4];

    always_comb begin
        w_rdata = 32'd0;
        case (w_adr)
            C_ADR_CTRL:   w_rdata = {28'd0, r_irq_en, r_lo_inv, r_hi_inv, r_en};
            C_ADR_DT:     w_rdata = 32'(r_deadtime);
            C_ADR_STATUS: w_rdata = {27'd0, r_state, r_fault_sync, r_fault_latched};
            default:      w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetb_i) begin
        if (!wb_resetb_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wb_we_i) ? w_rdata : 32'd0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetb_i) begin
        if (!wb_resetb_i) begin
            r_en       <= 1'b0;
            r_hi_inv   <= 1'b0;
            r_lo_inv   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_deadtime <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= wb_dat_i[0];
                r_hi_inv <= wb_dat_i[1];
                r_lo_inv <= wb_dat_i[2];
                r_irq_en <= wb_dat_i[3];
            end
            if (w_wr_dt) begin
                r_deadtime <= wb_dat_i[DT_BITS-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault synchroniser and latch; a present fault overrides a clear
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_resetb_i) begin
        if (!wb_resetb_i) begin
            r_fault_meta    <= 1'b0;
            r_fault_sync    <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_fault_meta <= fault_i;
            r_fault_sync <= r_fault_meta;
            if (r_fault_sync) begin
                r_fault_latched <= 1'b1;
            end else if (w_fault_clr) begin
                r_fault_latched <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dead-time FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_dt_cnt_nxt = r_dt_cnt;
        if (r_fault_sync || r_fault_latched) begin
            w_state_nxt = S_FAULT;
        end else if (!r_en) begin
            w_state_nxt = S_OFF;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt  = S_DEAD;
                    w_target_nxt = pwm_in;
                    w_dt_cnt_nxt = '0;
                end
                S_DEAD: begin
                    if (pwm_in != r_target) begin
                        w_target_nxt = pwm_in;
                        w_dt_cnt_nxt = '0;
                    end else if (r_dt_cnt == r_deadtime) begin
                        w_state_nxt = r_target ? S_HI : S_LO;
                    end else begin
                        // Wraps naturally if DEADTIME was lowered below the count
                        w_dt_cnt_nxt = r_dt_cnt + 1'b1;
                    end
                end
                S_HI: begin
                    if (!pwm_in) begin
                        w_state_nxt  = S_DEAD;
                        w_target_nxt = 1'b0;
                        w_dt_cnt_nxt = '0;
                    end
                end
                S_LO: begin
                    if (pwm_in) begin
                        w_state_nxt  = S_DEAD;
                        w_target_nxt = 1'b1;
                        w_dt_cnt_nxt = '0;
                    end
                end
                S_FAULT: w_state_nxt = S_OFF;
                default: w_state_nxt = S_OFF;
            endcase
        end
    end

    // Output flops decode the next state so the drive changes on the same edge
    assign w_hi_inv_nxt = w_wr_ctrl ? wb_dat_i[1] : r_hi_inv;
    assign w_lo_inv_nxt = w_wr_ctrl ? wb_dat_i[2] : r_lo_inv;

    always_ff @(posedge wb_clk_i or negedge wb_resetb_i) begin
        if (!wb_resetb_i) begin
            r_state  <= S_OFF;
            r_target <= 1'b0;
            r_dt_cnt <= '0;
            r_hi     <= 1'b0;
            r_lo     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_dt_cnt <= w_dt_cnt_nxt;
            r_hi     <= (w_state_nxt == S_HI) ^ w_hi_inv_nxt;
            r_lo     <= (w_state_nxt == S_LO) ^ w_lo_inv_nxt;
        end
    end

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat;
    assign pwm_hi_o    = r_hi;
    assign pwm_lo_o    = r_lo;
    assign fault_irq_o = r_fault_latched & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_pwm_deadtime_wb.sv
// ============================================================================
// Module  : tb_pwm_deadtime_wb
// Brief   : Directed and randomized checks of pwm_deadtime_wb.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pwm_deadtime_wb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = 32'd0;
    logic [31:0] adr = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic        pwm = 1'b0;
    logic        fault = 1'b0;
    logic        hi;
    logic        lo;
    logic        irq;

    int checks = 0;
    int errors = 0;

    pwm_deadtime_wb #(.DT_BITS(8)) dut (
        .wb_clk_i    (clk),
        .wb_resetb_i (rstn),
        .wb_stb_i    (stb),
        .wb_cyc_i    (cyc),
        .wb_we_i     (we),
        .wb_sel_i    (sel),
        .wb_dat_i    (wdat),
        .wb_adr_i    (adr),
        .wb_ack_o    (ack),
        .wb_dat_o    (rdat),
        .pwm_in      (pwm),
        .fault_i     (fault),
        .pwm_hi_o    (hi),
        .pwm_lo_o    (lo),
        .fault_irq_o (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for ack; leaves the bus request asserted
    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        tick();
        while (!ack && n < 4) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, ack}, 32'd1);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        wait_ack("wr_ack");
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        tick();
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        adr = a; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        wait_ack("rd_ack");
        d = rdat;
        stb = 1'b0; cyc = 1'b0; sel = 4'h0;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        int gap, ngaps, overlap, bad, dt, mrun;
        logic mlvl;

        // ---------------- Reset ----------------
        repeat (3) tick();
        chk("rst_hi", {31'd0, hi}, 32'd0);
        chk("rst_lo", {31'd0, lo}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rstn = 1'b1;
        tick();
        wb_rd(32'h08, d); chk("rst_status", d, 32'h0);

        // ---------------- Bus ----------------
        wb_wr(32'h04, 32'hA5, 4'hF);
        wb_rd(32'h04, d); chk("dt_rd", d, 32'hA5);
        adr = 32'h04; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        tick();
        chk("ack_hold1", {31'd0, ack}, 32'd1);
        tick();
        chk("ack_hold2", {31'd0, ack}, 32'd0);
        stb = 1'b0; cyc = 1'b0;
        tick();
        wb_rd(32'h40, d); chk("unmapped_rd", d, 32'h0);
        wb_wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        wb_rd(32'h08, d); chk("status_ro", d, 32'h0);
        wb_wr(32'h00, 32'h1E, 4'h1);
        wb_rd(32'h00, d); chk("ctrl_rd", d, 32'h0E);
        wb_wr(32'h00, 32'h01, 4'h0);
        wb_rd(32'h00, d); chk("ctrl_nosel", d, 32'h0E);
        wb_wr(32'h00, 32'h00, 4'hF);

        // ---------------- Test 1: dead time 3 ----------------
        wb_wr(32'h04, 32'd3, 4'hF);
        pwm = 1'b0;
        wb_wr(32'h00, 32'h01, 4'hF);
        repeat (10) tick();
        chk("t1_lo_on", {30'd0, hi, lo}, 32'b01);
        pwm = 1'b1;
        tick();
        chk("t1_edge_k", {30'd0, hi, lo}, 32'b00);
        repeat (2) tick();
        tick();
        chk("t1_edge_k3", {30'd0, hi, lo}, 32'b00);
        tick();
        chk("t1_edge_k4", {30'd0, hi, lo}, 32'b10);
        wb_rd(32'h08, d); chk("t1_state_hi", d, 32'h08);

        // ---------------- Test 2: square wave, DT=2 ----------------
        wb_wr(32'h04, 32'd2, 4'hF);
        gap = 0; ngaps = 0; overlap = 0;
        for (int c = 0; c < 100; c++) begin
            pwm = ((c % 20) < 10) ? 1'b0 : 1'b1;
            tick();
            if (hi && lo) overlap++;
            if (!hi && !lo) begin
                gap++;
            end else if (gap != 0) begin
                chk("t2_gap", gap, 32'd3);
                ngaps++;
                gap = 0;
            end
        end
        chk("t2_overlap", overlap, 32'd0);
        chk("t2_ngaps", ngaps, 32'd10);

        // ---------------- Test 3: fault ----------------
        wb_wr(32'h00, 32'h09, 4'hF);
        chk("t3_in_hi", {30'd0, hi, lo}, 32'b10);
        chk("t3_irq_pre", {31'd0, irq}, 32'd0);
        fault = 1'b1;
        repeat (2) tick();
        chk("t3_edge2", {30'd0, hi, lo}, 32'b10);
        tick();
        chk("t3_edge3", {30'd0, hi, lo}, 32'b00);
        chk("t3_irq", {31'd0, irq}, 32'd1);
        wb_rd(32'h08, d); chk("t3_status", d, 32'h13);
        wb_wr(32'h00, 32'h19, 4'hF);
        wb_rd(32'h08, d); chk("t3_clr_held", d, 32'h13);
        pwm = 1'b0;
        fault = 1'b0;
        repeat (3) tick();
        wb_rd(32'h08, d); chk("t3_status_drop", d, 32'h11);
        chk("t3_irq_held", {31'd0, irq}, 32'd1);
        wb_wr(32'h00, 32'h19, 4'hF);
        chk("t3_irq_clr", {31'd0, irq}, 32'd0);
        wb_rd(32'h08, d); chk("t3_off", d, 32'h00);
        wb_rd(32'h08, d); chk("t3_dead", d, 32'h04);
        repeat (4) tick();
        chk("t3_lo_on", {30'd0, hi, lo}, 32'b01);

        // ---------------- Test 4: polarity ----------------
        wb_wr(32'h00, 32'h06, 4'hF);
        chk("t4_off_inv", {30'd0, hi, lo}, 32'b11);
        wb_wr(32'h00, 32'h07, 4'hF);
        repeat (5) tick();
        chk("t4_lo_inv", {30'd0, hi, lo}, 32'b10);

        // ---------------- Test 5: glitches, DT=4 ----------------
        wb_wr(32'h00, 32'h01, 4'hF);
        chk("t5_lo", {30'd0, hi, lo}, 32'b01);
        wb_wr(32'h04, 32'd4, 4'hF);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            pwm = i[0] ? 1'b0 : 1'b1;
            tick();
            if (hi || lo) bad++;
        end
        chk("t5_inactive", bad, 32'd0);
        wb_rd(32'h08, d); chk("t5_dead", d, 32'h04);

        // ---------------- Reset mid-HI ----------------
        pwm = 1'b1;
        repeat (8) tick();
        chk("t6_hi", {30'd0, hi, lo}, 32'b10);
        rstn = 1'b0;
        #1;
        chk("t6_async", {30'd0, hi, lo}, 32'b00);
        chk("t6_irq", {31'd0, irq}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        wb_rd(32'h00, d); chk("t6_ctrl", d, 32'h0);
        wb_rd(32'h04, d); chk("t6_dt", d, 32'h0);
        wb_rd(32'h08, d); chk("t6_status", d, 32'h0);

        // ---------------- Randomized vs run-length model ----------------
        // A side turns on once its level has been sampled DT+2 times in a row.
        for (int r = 0; r < 3; r++) begin
            wb_wr(32'h00, 32'h00, 4'hF);
            dt = $urandom_range(0, 5);
            wb_wr(32'h04, dt, 4'hF);
            pwm = 1'b0;
            wb_wr(32'h00, 32'h01, 4'hF);
            repeat (15) tick();
            mlvl = 1'b0;
            mrun = 100;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 3) == 0) pwm = ~pwm;
                tick();
                if (pwm == mlvl) begin
                    if (mrun < 100) mrun++;
                end else begin
                    mlvl = pwm;
                    mrun = 1;
                end
                chk("rnd_hi", {31'd0, hi}, {31'd0, (mlvl == 1'b1) && (mrun >= dt + 2)});
                chk("rnd_lo", {31'd0, lo}, {31'd0, (mlvl == 1'b0) && (mrun >= dt + 2)});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
